encrypt_pipe_permutation: RTL
=============================

ENCRYPT_PIPE_PERMUTATION -- requirements
Module: encrypt_pipe_permutation

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 cfg_wr  input  1  write cfg_val into shadow table entry cfg_idx.
REQ-004 cfg_idx  input  3  shadow table index (output bit position).
REQ-005 cfg_val  input  3  source bit index for that output bit.
REQ-006 cfg_commit  input  1  request shadow-to-active table transfer.
REQ-007 in_valid  input  1  plaintext beat offered.
REQ-008 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-009 data_in  input  8  plaintext byte.
REQ-010 out_valid  output  1  ciphertext beat available.
REQ-011 out_ready  input  1  beat consumed when out_valid && out_ready.
REQ-012 data_out  output  8  ciphertext byte.
REQ-013 commit_done  output  1  one-cycle pulse: new table active.
REQ-014 perm_err  output  1  last commit rejected (shadow not a bijection).

Function
REQ-015 Encryption SHALL be data_out[i] = data_in[perm[i]] for i = 0..7 using the active table at acceptance, the exact inverse of the decrypt stage programmed with the same eight values.
REQ-016 Accepted beats SHALL enter a 2-entry in-order output buffer with permutation applied on write; latency accept-to-out_valid = 1 cycle.
REQ-017 in_ready SHALL be 1 only when state = IDLE and buffer count < 2; a full buffer SHALL NOT accept even if out_ready = 1 that cycle.
REQ-018 Simultaneous push and pop at count 1 SHALL keep count 1 with order preserved; pop at count 0 impossible (out_valid = 0).
REQ-019 data_out and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-020 cfg_wr SHALL update shadow only in IDLE; ignored otherwise.
REQ-021 FSM states IDLE, CHECK, DRAIN, APPLY: IDLE --cfg_commit--> CHECK; CHECK --illegal--> IDLE (set perm_err); CHECK --legal--> DRAIN; DRAIN --count = 0--> APPLY; APPLY --> IDLE (copy shadow to active, pulse commit_done, clear perm_err).
REQ-022 cfg_wr and cfg_commit in the same IDLE cycle: write lands first, CHECK evaluates the updated shadow.
REQ-023 Legality: all eight shadow entries pairwise distinct; any duplicate is illegal.
REQ-024 Rejected commit SHALL leave the active table unchanged; perm_err stays 1 until a successful commit or reset.
REQ-025 cfg_commit outside IDLE SHALL be ignored.
REQ-026 Buffered beats SHALL keep the permutation in force at their acceptance.

Reset
REQ-027 On rst = 0: shadow and active tables = identity (perm[i] = i), buffer count 0, state IDLE, out_valid 0, data_out 0x00, in_ready 0, commit_done 0, perm_err 0.
REQ-028 Reset mid-operation SHALL discard buffered beats and any pending commit; in_ready = 1 the first cycle after release.

Structure
REQ-029 Shared package encrypt_pkg SHALL hold DATA_W = 8, PERM_W = 3, perm_table_t (8 x 3-bit array) and the FSM state enum, also used by the decrypt side.
REQ-030 The 2-entry output buffer SHALL be the single sub-module encrypt_out_buf (push/pop/count, 8-bit payload).

Verification
REQ-031 After reset, identity table: send 0xA5 -> data_out 0xA5 one cycle later.
REQ-032 Program perm[i] = 7-i, commit -> commit_done pulse, perm_err 0; send 0x01 -> 0x80, 0x0F -> 0xF0.
REQ-033 Shadow perm[0] = perm[1] = 0, commit -> perm_err 1, no commit_done; send 0x01 -> still 0x80 under reversal table.
REQ-034 out_ready = 0, offer 3 beats 0x11, 0x22, 0x33 -> 2 accepted, in_ready 0; raise out_ready -> 0x11, 0x22 out in order, then 0x33 accepted.
REQ-035 Two beats buffered with out_ready = 0, then legal commit -> FSM holds in DRAIN, in_ready 0, buffered beats use old table, commit_done one cycle after buffer empties.
REQ-036 Assert rst with count = 2 and FSM in DRAIN -> out_valid 0, state IDLE, identity table; 0x3C then passes unchanged.

Source files
------------

// File: rtl/encrypt_pkg.sv
// rtl/encrypt_pkg.sv - shared widths, permutation table type, FSM states and helpers
package encrypt_pkg;

    localparam int DATA_W = 8;
    localparam int PERM_W = 3;

    typedef logic [PERM_W-1:0] perm_idx_t;
    typedef perm_idx_t [DATA_W-1:0] perm_table_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DRAIN = 2'd2,
        ST_APPLY = 2'd3
    } perm_state_e;

    function automatic perm_table_t identity_table();
        perm_table_t t;
        for (int i = 0; i < DATA_W; i++) begin
            t[i] = PERM_W'(i);
        end
        return t;
    endfunction

    function automatic logic [DATA_W-1:0] permute(input logic [DATA_W-1:0] data,
                                                   input perm_table_t      t);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = data[t[i]];
        end
        return r;
    endfunction

    // Eight 3-bit entries are pairwise distinct exactly when every source bit is hit.
    function automatic logic is_bijection(input perm_table_t t);
        logic [DATA_W-1:0] seen;
        seen = '0;
        for (int i = 0; i < DATA_W; i++) begin
            seen[t[i]] = 1'b1;
        end
        return &seen;
    endfunction

endpackage

// File: rtl/encrypt_out_buf.sv
// rtl/encrypt_out_buf.sv - 2-entry in-order output buffer with push/pop/count
module encrypt_out_buf
    import encrypt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic [1:0]        count_o
);

    logic [1:0][DATA_W-1:0] mem_q;
    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [1:0]             count_q;
    logic [1:0]             count_d;
    logic                   do_push;
    logic                   do_pop;

    assign do_push = push_i && (count_q != 2'd2);
    assign do_pop  = pop_i && (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/encrypt_pipe_permutation.sv
// rtl/encrypt_pipe_permutation.sv - bit-permutation encryptor with shadow/active tables and safe commit
module encrypt_pipe_permutation
    import encrypt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [PERM_W-1:0] cfg_idx,
    input  logic [PERM_W-1:0] cfg_val,
    input  logic              cfg_commit,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              commit_done,
    output logic              perm_err
);

    perm_state_e state_q, state_d;
    perm_table_t shadow_q, shadow_d;
    perm_table_t active_q, active_d;
    logic        perm_err_q, perm_err_d;
    logic        commit_done_q, commit_done_d;
    logic [1:0]  buf_count;
    logic        accept;

    // Gated by rst so in_ready reads 0 while reset is held.
    assign in_ready = rst && (state_q == ST_IDLE) && (buf_count != 2'd2);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        perm_err_d    = perm_err_q;
        commit_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_wr) begin
                    shadow_d[cfg_idx] = cfg_val;
                end
                if (cfg_commit) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (is_bijection(shadow_q)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d    = ST_IDLE;
                    perm_err_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (buf_count == 2'd0) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                active_d      = shadow_q;
                commit_done_d = 1'b1;
                perm_err_d    = 1'b0;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            shadow_q      <= identity_table();
            active_q      <= identity_table();
            perm_err_q    <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            perm_err_q    <= perm_err_d;
            commit_done_q <= commit_done_d;
        end
    end

    // Permuting on write freezes each beat under the table active at its acceptance.
    encrypt_out_buf u_out_buf (
        .clk         (clk),
        .rst_ni      (rst),
        .push_i      (accept),
        .push_data_i (permute(data_in, active_q)),
        .pop_i       (out_ready),
        .pop_data_o  (data_out),
        .count_o     (buf_count)
    );

    assign out_valid   = (buf_count != 2'd0);
    assign commit_done = commit_done_q;
    assign perm_err    = perm_err_q;

endmodule
